// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - DEPTH x WIDTH register file, one write port, two registered read ports.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int ZERO_REG = 0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re_a,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic             re_b,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b
);

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_ok;
   logic [WIDTH-1:0] rd_next_a;
   logic [WIDTH-1:0] rd_next_b;

   // An address is live only if it exists and is not the hardwired zero word.
   function automatic logic addr_live(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   always_comb begin
      wr_ok = we && addr_live(waddr);
   end

   always_comb begin
      rd_next_a = '0;
      if (addr_live(raddr_a)) begin
         if (BYPASS && wr_ok && (raddr_a == waddr)) rd_next_a = wdata;
         else                                       rd_next_a = mem[raddr_a];
      end
   end

   always_comb begin
      rd_next_b = '0;
      if (addr_live(raddr_b)) begin
         if (BYPASS && wr_ok && (raddr_b == waddr)) rd_next_b = wdata;
         else                                       rd_next_b = mem[raddr_b];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && (waddr == AW'(i))) mem[i] <= wdata;
         end
         if (re_a) rdata_a <= rd_next_a;
         if (re_b) rdata_b <= rd_next_b;
      end
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed bench for regfile_2r1w (DEPTH=8 plain, DEPTH=6 with ZERO_REG).
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        rst;

   logic        we, re_a, re_b;
   logic [2:0]  waddr, raddr_a, raddr_b;
   logic [15:0] wdata, rdata_a, rdata_b;

   logic        we6, re_a6, re_b6;
   logic [2:0]  waddr6, raddr_a6, raddr_b6;
   logic [15:0] wdata6, rdata_a6, rdata_b6;

   int checks = 0;
   int errors = 0;

`ifdef REGFILE_BYPASS_EN
   localparam logic [15:0] RDW_EXP = 16'h2222;
`else
   localparam logic [15:0] RDW_EXP = 16'h1111;
`endif

   always #5 clk = ~clk;

   regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) u_dut (
      .clk(clk), .rst(rst),
      .we(we), .waddr(waddr), .wdata(wdata),
      .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
      .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
   );

   regfile_2r1w #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1)) u_dut6 (
      .clk(clk), .rst(rst),
      .we(we6), .waddr(waddr6), .wdata(wdata6),
      .re_a(re_a6), .raddr_a(raddr_a6), .rdata_a(rdata_a6),
      .re_b(re_b6), .raddr_b(raddr_b6), .rdata_b(rdata_b6)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle8();
      we = 1'b0; re_a = 1'b0; re_b = 1'b0;
      waddr = '0; raddr_a = '0; raddr_b = '0; wdata = '0;
   endtask

   task automatic idle6();
      we6 = 1'b0; re_a6 = 1'b0; re_b6 = 1'b0;
      waddr6 = '0; raddr_a6 = '0; raddr_b6 = '0; wdata6 = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle8();
      idle6();
      tick();
      chk("reset_rdata_a", rdata_a, 16'h0000);
      chk("reset_rdata_b", rdata_b, 16'h0000);
      chk("reset_rdata_a6", rdata_a6, 16'h0000);
      chk("reset_rdata_b6", rdata_b6, 16'h0000);

      // Fill with 0xBEEF starting at the reset-release edge.
      rst = 1'b0;
      we = 1'b1; wdata = 16'hBEEF;
      for (int i = 0; i < 8; i++) begin
         waddr = 3'(i);
         tick();
      end
      idle8();
      re_a = 1'b1; raddr_a = 3'd4; re_b = 1'b1; raddr_b = 3'd7;
      tick();
      chk("fill_read_a4", rdata_a, 16'hBEEF);
      chk("fill_read_b7", rdata_b, 16'hBEEF);

      // Reset overrides a concurrent write and reads.
      rst = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 16'h7777;
      raddr_a = 3'd1; raddr_b = 3'd2;
      tick();
      chk("rst_override_a", rdata_a, 16'h0000);
      chk("rst_override_b", rdata_b, 16'h0000);
      rst = 1'b0;
      idle8();
      re_a = 1'b1; re_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
         raddr_a = 3'(i); raddr_b = 3'(7 - i);
         tick();
         chk($sformatf("post_rst_a%0d", i), rdata_a, 16'h0000);
         chk($sformatf("post_rst_b%0d", 7 - i), rdata_b, 16'h0000);
      end
      idle8();

      // Basic write then dual read.
      we = 1'b1; waddr = 3'd3; wdata = 16'h1234;
      tick();
      waddr = 3'd5; wdata = 16'hABCD;
      tick();
      idle8();
      re_a = 1'b1; raddr_a = 3'd3; re_b = 1'b1; raddr_b = 3'd5;
      tick();
      chk("rw_a3", rdata_a, 16'h1234);
      chk("rw_b5", rdata_b, 16'hABCD);

      // Hold with read enables low while the word changes underneath.
      idle8();
      raddr_a = 3'd3;
      we = 1'b1; waddr = 3'd3; wdata = 16'h0000;
      tick();
      chk("hold_a", rdata_a, 16'h1234);
      chk("hold_b", rdata_b, 16'hABCD);
      we = 1'b0;
      tick();
      chk("hold_a_2", rdata_a, 16'h1234);
      re_a = 1'b1;
      tick();
      chk("reread_a3", rdata_a, 16'h0000);
      chk("hold_b_2", rdata_b, 16'hABCD);

      // Same-address read on both ports.
      idle8();
      re_a = 1'b1; re_b = 1'b1; raddr_a = 3'd5; raddr_b = 3'd5;
      tick();
      chk("same_addr_a", rdata_a, 16'hABCD);
      chk("same_addr_b", rdata_b, 16'hABCD);

      // Read-during-write on both ports.
      idle8();
      we = 1'b1; waddr = 3'd2; wdata = 16'h1111;
      tick();
      wdata = 16'h2222; re_a = 1'b1; raddr_a = 3'd2; re_b = 1'b1; raddr_b = 3'd2;
      tick();
      chk("rdw_a", rdata_a, RDW_EXP);
      chk("rdw_b", rdata_b, RDW_EXP);
      we = 1'b0;
      tick();
      chk("after_rdw_a", rdata_a, 16'h2222);
      chk("after_rdw_b", rdata_b, 16'h2222);
      idle8();

      // DEPTH=6, ZERO_REG=1 instance: bounds and hardwired zero word.
      we6 = 1'b1; waddr6 = 3'd5; wdata6 = 16'h0A0A;
      tick();
      waddr6 = 3'd7; wdata6 = 16'hFFFF;
      tick();
      waddr6 = 3'd6; wdata6 = 16'hEEEE;
      tick();
      we6 = 1'b0;
      re_a6 = 1'b1; raddr_a6 = 3'd7; re_b6 = 1'b1; raddr_b6 = 3'd5;
      tick();
      chk("oob_read_a7", rdata_a6, 16'h0000);
      chk("mem5_intact_b", rdata_b6, 16'h0A0A);
      raddr_a6 = 3'd6; raddr_b6 = 3'd4;
      tick();
      chk("oob_read_a6", rdata_a6, 16'h0000);
      chk("unwritten_b4", rdata_b6, 16'h0000);

      // Out-of-range write never forwards.
      we6 = 1'b1; waddr6 = 3'd7; wdata6 = 16'h1357; raddr_a6 = 3'd7; raddr_b6 = 3'd5;
      tick();
      chk("oob_no_fwd_a", rdata_a6, 16'h0000);
      chk("oob_mem5_b", rdata_b6, 16'h0A0A);

      // Zero word: write suppressed, no forwarding, stays zero.
      waddr6 = 3'd0; wdata6 = 16'h5A5A; raddr_a6 = 3'd0; raddr_b6 = 3'd0;
      tick();
      chk("zero_fwd_a", rdata_a6, 16'h0000);
      chk("zero_fwd_b", rdata_b6, 16'h0000);
      we6 = 1'b0;
      tick();
      chk("zero_later_a", rdata_a6, 16'h0000);
      raddr_b6 = 3'd5;
      tick();
      chk("final_mem5_b", rdata_b6, 16'h0A0A);
      idle6();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
